// File: rtl/key_sel_if.sv
// ---------------------------------------------------------------------------
// key_sel_if
// Purpose : Bundles the key/selection signals of key_sel_ctrl so that the
//           controller and its user share one connection object.
// Signals : key_in      - raw key levels, active-high, asynchronous
//           key_level   - debounced key levels
//           key_press   - one-cycle pulse per accepted 0->1 transition
//           key_release - one-cycle pulse per accepted 1->0 transition
//           sel_out     - selection index
//           sys_rst     - stretched, active-high system reset
//           long_press  - key0 long-press pulse (only with KEY_LONG_PRESS_EN)
// Modports: master drives key_in and observes the rest; slave is the
//           controller side.
// Macro   : KEY_LONG_PRESS_EN adds the long_press signal.
// ---------------------------------------------------------------------------
interface key_sel_if #(
  parameter int NUM_KEYS = 4,
  parameter int SEL_W    = 2
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [SEL_W-1:0]    sel_out;
  logic                sys_rst;

`ifdef KEY_LONG_PRESS_EN
  logic                long_press;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, sel_out, sys_rst, long_press
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, sel_out, sys_rst, long_press
  );
`else
  modport master (
    output key_in,
    input  key_level, key_press, key_release, sel_out, sys_rst
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, sel_out, sys_rst
  );
`endif
endinterface

// File: rtl/key_sel_ctrl.sv
// ---------------------------------------------------------------------------
// key_sel_ctrl
// Purpose : Debounces NUM_KEYS raw key inputs, turns key0/key1 presses into
//           an up/down wrapping selection index and produces a stretched
//           system reset that holds the key logic idle after power-up.
// Ports   : clk   - sole clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - key_sel_if.slave (key_in in; key_level, key_press,
//                   key_release, sel_out, sys_rst [, long_press] out)
// Macro   : KEY_LONG_PRESS_EN enables the key0 long-press detector, its
//           LONG_CYCLES parameter and the long_press output. Without it the
//           detector is absent and everything else behaves the same.
// ---------------------------------------------------------------------------
module key_sel_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int CNT_W           = 16,
  parameter int SEL_W           = 2,
  parameter int SEL_MAX         = 3,
  parameter int RST_STRETCH     = 15
`ifdef KEY_LONG_PRESS_EN
  , parameter int LONG_CYCLES   = 5_000_000
`endif
) (
  input  logic      clk,
  input  logic      rst_n,
  key_sel_if.slave  bus
);

  typedef enum logic [1:0] {IDLE_LO, DEB_HI, IDLE_HI, DEB_LO} chanState_t;

  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_TOP      = SEL_W'(SEL_MAX);
  localparam logic [7:0]       STRETCH_INIT = 8'(RST_STRETCH);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [7:0]          r_stretchCnt;
  logic                r_sysRst;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [SEL_W-1:0]    r_sel;
  logic                w_longPress;

  // Two-flop synchroniser: raw keys are asynchronous to clk, so nothing
  // downstream may look at them before they have settled through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Reset stretcher: sys_rst is registered so it deasserts cleanly. It drops
  // on the same edge at which the counter steps from 1 to 0, which makes the
  // fall land on the RST_STRETCH-th edge after rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stretchCnt <= STRETCH_INIT;
      r_sysRst     <= 1'b1;
    end else if (r_stretchCnt != 8'd0) begin
      r_stretchCnt <= r_stretchCnt - 8'd1;
      r_sysRst     <= (r_stretchCnt > 8'd1);
    end
  end

  // One debounce machine per key. The counter counts consecutive cycles the
  // synchronised input has held the new level, the entry cycle counting as
  // 1; the level is accepted on the cycle the D-th such sample is seen, so
  // the pulse lands exactly 2 + DEBOUNCE_CYCLES edges after the raw change.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    chanState_t       r_state;
    chanState_t       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_nextLevel;
    logic             w_nextPress;
    logic             w_nextRelease;

    // Next-state logic; the stretched reset pins the channel in IDLE_LO.
    always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextLevel   = r_level;
      w_nextPress   = 1'b0;
      w_nextRelease = 1'b0;
      if (r_sysRst) begin
        w_nextState = IDLE_LO;
        w_nextCnt   = '0;
        w_nextLevel = 1'b0;
      end else begin
        case (r_state)
          IDLE_LO: begin
            if (r_sync2[g]) begin
              w_nextState = DEB_HI;
              w_nextCnt   = CNT_W'(1);
            end
          end
          DEB_HI: begin
            if (!r_sync2[g]) begin
              w_nextState = IDLE_LO;
              w_nextCnt   = '0;
            end else if (r_cnt == DEB_LAST) begin
              w_nextState = IDLE_HI;
              w_nextCnt   = '0;
              w_nextLevel = 1'b1;
              w_nextPress = 1'b1;
            end else begin
              w_nextCnt = r_cnt + CNT_W'(1);
            end
          end
          IDLE_HI: begin
            if (!r_sync2[g]) begin
              w_nextState = DEB_LO;
              w_nextCnt   = CNT_W'(1);
            end
          end
          DEB_LO: begin
            if (r_sync2[g]) begin
              w_nextState = IDLE_HI;
              w_nextCnt   = '0;
            end else if (r_cnt == DEB_LAST) begin
              w_nextState   = IDLE_LO;
              w_nextCnt     = '0;
              w_nextLevel   = 1'b0;
              w_nextRelease = 1'b1;
            end else begin
              w_nextCnt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_nextState = IDLE_LO;
            w_nextCnt   = '0;
          end
        endcase
      end
    end

    // State and output registers for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= IDLE_LO;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_nextState;
        r_cnt     <= w_nextCnt;
        r_level   <= w_nextLevel;
        r_press   <= w_nextPress;
        r_release <= w_nextRelease;
      end
    end

    assign w_level[g]   = r_level;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [23:0] LONG_TGT = 24'(LONG_CYCLES);

  logic [23:0] r_longCnt;
  logic        r_longPress;

  // Long-press timer: counts while key0 is held and saturates at the
  // target, so one hold yields exactly one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_longCnt   <= '0;
      r_longPress <= 1'b0;
    end else begin
      r_longPress <= 1'b0;
      if (r_sysRst || !w_level[0]) begin
        r_longCnt <= '0;
      end else if (r_longCnt != LONG_TGT) begin
        r_longCnt   <= r_longCnt + 24'd1;
        r_longPress <= (r_longCnt == LONG_TGT - 24'd1);
      end
    end
  end

  assign w_longPress    = r_longPress;
  assign bus.long_press = r_longPress;
`else
  assign w_longPress = 1'b0;
`endif

  // Selection index: follows the registered press pulses one edge later.
  // Simultaneous key0/key1 presses cancel; a long press forces zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
    end else if (r_sysRst || w_longPress) begin
      r_sel <= '0;
    end else if (w_press[0] && !w_press[1]) begin
      r_sel <= (r_sel == SEL_TOP) ? '0 : r_sel + SEL_W'(1);
    end else if (w_press[1] && !w_press[0]) begin
      r_sel <= (r_sel == '0) ? SEL_TOP : r_sel - SEL_W'(1);
    end
  end

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;
  assign bus.sel_out     = r_sel;
  assign bus.sys_rst     = r_sysRst;

endmodule

// File: doc/key_sel_ctrl.md
KEY_SEL_CTRL -- requirements
Module: key_sel_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of key channels; legal range 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50_000: consecutive stable cycles needed to accept a level change; legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16: width of each debounce counter.
REQ-004 SHALL have parameter SEL_W, default 2: width of sel_out.
REQ-005 SHALL have parameter SEL_MAX, default 3: highest sel_out value; legal range up to 2^SEL_W-1.
REQ-006 SHALL have parameter RST_STRETCH, default 15: number of cycles sys_rst stays high after rst_n deasserts; legal range 1..255.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 key_in  input  NUM_KEYS  raw key levels, asynchronous, active-high (pressed = 1).
REQ-010 key_level  output  NUM_KEYS  debounced key levels.
REQ-011 key_press  output  NUM_KEYS  one-cycle pulse per channel on each accepted 0->1 transition.
REQ-012 key_release  output  NUM_KEYS  one-cycle pulse per channel on each accepted 1->0 transition.
REQ-013 sel_out  output  SEL_W  selection index (CPU select).
REQ-014 sys_rst  output  1  stretched, active-high, synchronously deasserted system reset.
REQ-015 long_press  output  1  one-cycle pulse for a key0 long press; present only when KEY_LONG_PRESS_EN is defined.

Function
REQ-016 Each key_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 Each channel SHALL run its own state machine with states IDLE_LO, DEB_HI, IDLE_HI and DEB_LO, plus a CNT_W-bit counter.
REQ-018 In IDLE_LO, a synchronised value of 1 SHALL move the channel to DEB_HI with the counter at 1; in DEB_HI, a synchronised 0 SHALL return it to IDLE_LO with the counter at 0.
REQ-019 In DEB_HI, when the counter reaches DEBOUNCE_CYCLES with the input still 1, the channel SHALL enter IDLE_HI, set key_level to 1, pulse key_press for one cycle and clear the counter.
REQ-020 Transitions IDLE_HI -> DEB_LO -> IDLE_LO SHALL mirror REQ-018/019, setting key_level to 0 and pulsing key_release.
REQ-021 Latency from a clean key_in edge to the key_press/key_release pulse SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-022 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and no key_level change.
REQ-023 key_press[0] SHALL increment sel_out, wrapping from SEL_MAX to 0.
REQ-024 key_press[1] SHALL decrement sel_out, wrapping from 0 to SEL_MAX.
REQ-025 When key_press[0] and key_press[1] occur in the same cycle, sel_out SHALL remain unchanged.
REQ-026 sel_out SHALL update on the clock edge after the key_press pulse.
REQ-027 Keys 2..NUM_KEYS-1 SHALL only drive key_level, key_press and key_release.
REQ-028 While sys_rst is 1, all channel state machines SHALL be held in IDLE_LO and sel_out SHALL be held at 0.
REQ-029 The sys_rst stretch counter SHALL load RST_STRETCH on reset and decrement by 1 per cycle.
REQ-030 sys_rst SHALL be 1 while the stretch counter is nonzero and 0 once it reaches 0.

Reset
REQ-031 rst_n low SHALL asynchronously clear synchronisers, counters, key_level, key_press, key_release, sel_out and long_press to 0, set all states to IDLE_LO, and set sys_rst to 1.
REQ-032 Reset asserted mid-debounce or mid-long-press SHALL abort the operation with no pulse emitted, either then or after reset.
REQ-033 After rst_n rises, sys_rst SHALL fall on the RST_STRETCH-th rising clk edge.

Configuration
REQ-034 Macro KEY_LONG_PRESS_EN defined: a 24-bit counter SHALL run while key_level[0] is 1, and long_press SHALL pulse once when the counter reaches parameter LONG_CYCLES (default 5_000_000).
REQ-035 With KEY_LONG_PRESS_EN defined, a long press SHALL also force sel_out to 0, and the key_press-driven increment at press time SHALL still occur.
REQ-036 Macro KEY_LONG_PRESS_EN undefined: the long_press port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset: rst_n low, RST_STRETCH=15 -> all outputs 0 except sys_rst=1; after rst_n rises, sys_rst falls on the 15th edge.
REQ-038 Clean press: DEBOUNCE_CYCLES=8, key_in[2] rises -> key_press[2] pulses 10 cycles later and key_level[2]=1; sel_out unchanged.
REQ-039 Bounce: DEBOUNCE_CYCLES=8, key_in[0] toggles with 5-cycle high and 3-cycle low periods for 40 cycles -> no key_press[0] and sel_out stays 0.
REQ-040 Wrap: SEL_MAX=3, four key0 presses -> sel_out sequence 1, 2, 3, 0; then one key1 press -> sel_out 3.
REQ-041 Simultaneous: key0 and key1 pressed on the same cycle -> key_press[0] and key_press[1] pulse together and sel_out is unchanged.
REQ-042 Long press: KEY_LONG_PRESS_EN defined, LONG_CYCLES=100, sel_out=2, key0 held for 200 cycles -> sel_out goes to 3, then long_press pulses once and sel_out becomes 0.
